// File: rtl/reg_file_pkg.sv
// reg_file_pkg: definitions shared by the multi-port register file and its users.
//   - default geometry (DEF_DATA_WIDTH, DEF_DEPTH)
//   - system register indices and their reset values
//   - DEF_RESET_VALS: default flattened reset image for those registers
//   - reset_slice(): extracts register i from a flattened reset image
package reg_file_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 16;

    // System register map (indices into the file).
    localparam int REG_UART_CFG = 2;
    localparam int REG_DIV      = 3;

    localparam logic [DEF_DATA_WIDTH-1:0] REG_UART_CFG_RST = 8'h81;
    localparam logic [DEF_DATA_WIDTH-1:0] REG_DIV_RST      = 8'h20;

    localparam int DEF_IMG_BITS = DEF_DEPTH * DEF_DATA_WIDTH;

    localparam logic [DEF_IMG_BITS-1:0] DEF_RESET_VALS =
        (DEF_IMG_BITS'(REG_UART_CFG_RST) << (REG_UART_CFG * DEF_DATA_WIDTH)) |
        (DEF_IMG_BITS'(REG_DIV_RST)      << (REG_DIV * DEF_DATA_WIDTH));

    // Largest reset image and register width reset_slice() accepts. Callers
    // widen their image to MAX_IMG_BITS and narrow the result to their width.
    localparam int MAX_IMG_BITS   = 4096;
    localparam int MAX_DATA_WIDTH = 64;

    function automatic logic [MAX_DATA_WIDTH-1:0] reset_slice(
        input logic [MAX_IMG_BITS-1:0] img,
        input int                      idx,
        input int                      dw
    );
        return MAX_DATA_WIDTH'(img >> (idx * dw));
    endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: bus between the system controller / datapath and the
// multi-port register file.
//   master: drives write and read requests, receives read data and errors
//   slave : the register file
// Signals: WrEn/WrAddr/WrData, RdEnA/RdAddrA -> RdDataA/RdDataA_VLD,
//          RdEnB/RdAddrB -> RdDataB/RdDataB_VLD, WrErr, RdErr, REG_OUT.
interface reg_file_mp_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_EXPORT = 4
);
    logic                             WrEn;
    logic [ADDR_WIDTH-1:0]            WrAddr;
    logic [DATA_WIDTH-1:0]            WrData;

    logic                             RdEnA;
    logic [ADDR_WIDTH-1:0]            RdAddrA;
    logic [DATA_WIDTH-1:0]            RdDataA;
    logic                             RdDataA_VLD;

    logic                             RdEnB;
    logic [ADDR_WIDTH-1:0]            RdAddrB;
    logic [DATA_WIDTH-1:0]            RdDataB;
    logic                             RdDataB_VLD;

    logic                             WrErr;
    logic                             RdErr;
    logic [NUM_EXPORT*DATA_WIDTH-1:0] REG_OUT;

    modport master (
        output WrEn, WrAddr, WrData,
        output RdEnA, RdAddrA, RdEnB, RdAddrB,
        input  RdDataA, RdDataA_VLD, RdDataB, RdDataB_VLD,
        input  WrErr, RdErr, REG_OUT
    );

    modport slave (
        input  WrEn, WrAddr, WrData,
        input  RdEnA, RdAddrA, RdEnB, RdAddrB,
        output RdDataA, RdDataA_VLD, RdDataB, RdDataB_VLD,
        output WrErr, RdErr, REG_OUT
    );
endinterface

// File: rtl/reg_file_rd_port.sv
// reg_file_rd_port: one registered read port of the register file.
//   rd_en/rd_addr : read request
//   rd_raw        : stored contents at rd_addr (muxed by the parent)
//   wr_acc/wr_addr/wr_data : accepted write this cycle, for the bypass path
//   rd_data/rd_vld/rd_err  : registered result, one cycle after the request
module reg_file_rd_port #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_raw,
    input  logic                  wr_acc,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_vld,
    output logic                  rd_err
);

    // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] data_d, data_q;
    logic                  vld_d, vld_q;
    logic                  err_d, err_q;
    logic                  in_range;

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        data_d   = data_q;
        vld_d    = 1'b0;
        err_d    = 1'b0;
        in_range = ({1'b0, rd_addr} < DEPTH_W);
        if (rd_en) begin
            vld_d = 1'b1;
            if (!in_range) begin
                data_d = '0;
                err_d  = 1'b1;
            end else if (BYPASS && wr_acc && (wr_addr == rd_addr)) begin
                data_d = wr_data;
            end else begin
                data_d = rd_raw;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst) begin
            data_q <= '0;
            vld_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
            err_q  <= err_d;
        end
    end

    assign rd_data = data_q;
    assign rd_vld  = vld_q;
    assign rd_err  = err_q;

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised register file, one write port, two read ports.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : reg_file_mp_if slave (write port, read ports A/B, WrErr,
//              RdErr, REG_OUT export of registers 0..NUM_EXPORT-1)
// Writes to out-of-range or read-only registers are dropped and flagged on
// WrErr. Reads have one cycle of latency; BYPASS selects whether a read of
// the register being written returns the new or the old value.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int                            DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int                            DEPTH      = DEF_DEPTH,
    parameter int                            ADDR_WIDTH = 4,
    parameter int                            NUM_EXPORT = 4,
    parameter logic [DEPTH*DATA_WIDTH-1:0]   RESET_VALS = '0,
    parameter logic [DEPTH-1:0]              RO_MASK    = '0,
    parameter bit                            BYPASS     = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    reg_file_mp_if.slave bus
);

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  wr_ro;
    logic                  wr_in_range;
    logic                  wr_ok;
    logic                  wr_err_d, wr_err_q;

    logic [DATA_WIDTH-1:0] rd_raw_a, rd_raw_b;
    logic [DATA_WIDTH-1:0] rd_data_a, rd_data_b;
    logic                  rd_vld_a, rd_vld_b;
    logic                  rd_err_a, rd_err_b;

    logic [NUM_EXPORT*DATA_WIDTH-1:0] reg_out;

    // Write qualification and next-state of storage.
    always_comb begin
        wr_ro = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.WrAddr == ADDR_WIDTH'(i)) wr_ro = RO_MASK[i];
        end
        wr_in_range = ({1'b0, bus.WrAddr} < DEPTH_W);
        wr_ok       = bus.WrEn && wr_in_range && !wr_ro;
        wr_err_d    = bus.WrEn && !wr_ok;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (wr_ok && (bus.WrAddr == ADDR_WIDTH'(i))) mem_d[i] = bus.WrData;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: storage is reset on purpose: each register has an
            // architectural reset value and REG_OUT drives live consumers.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= DATA_WIDTH'(reset_slice(MAX_IMG_BITS'(RESET_VALS), i, DATA_WIDTH));
            end
            wr_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_err_q <= wr_err_d;
        end
    end

    // Stored contents at each read address; out-of-range addresses fall
    // through as zero and are handled in the read port.
    always_comb begin
        rd_raw_a = '0;
        rd_raw_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.RdAddrA == ADDR_WIDTH'(i)) rd_raw_a = mem_q[i];
            if (bus.RdAddrB == ADDR_WIDTH'(i)) rd_raw_b = mem_q[i];
        end
    end

    reg_file_rd_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .BYPASS     (BYPASS)
    ) u_rd_a (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (bus.RdEnA),
        .rd_addr (bus.RdAddrA),
        .rd_raw  (rd_raw_a),
        .wr_acc  (wr_ok),
        .wr_addr (bus.WrAddr),
        .wr_data (bus.WrData),
        .rd_data (rd_data_a),
        .rd_vld  (rd_vld_a),
        .rd_err  (rd_err_a)
    );

    reg_file_rd_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .BYPASS     (BYPASS)
    ) u_rd_b (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (bus.RdEnB),
        .rd_addr (bus.RdAddrB),
        .rd_raw  (rd_raw_b),
        .wr_acc  (wr_ok),
        .wr_addr (bus.WrAddr),
        .wr_data (bus.WrData),
        .rd_data (rd_data_b),
        .rd_vld  (rd_vld_b),
        .rd_err  (rd_err_b)
    );

    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_EXPORT; i++) begin
            reg_out[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i];
        end
    end

    assign bus.RdDataA     = rd_data_a;
    assign bus.RdDataA_VLD = rd_vld_a;
    assign bus.RdDataB     = rd_data_b;
    assign bus.RdDataB_VLD = rd_vld_b;
    assign bus.WrErr       = wr_err_q;
    assign bus.RdErr       = rd_err_a | rd_err_b;
    assign bus.REG_OUT     = reg_out;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp. Two instances share clock and reset:
//   u0: DEPTH=16, BYPASS=1, register 1 read-only
//   u1: DEPTH=12, BYPASS=0
// Both use the default system reset image (reg2=8'h81, reg3=8'h20).
module tb_reg_file_mp;
    import reg_file_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    reg_file_mp_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_EXPORT(4)) b0 ();
    reg_file_mp_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_EXPORT(4)) b1 ();

    reg_file_mp #(
        .DATA_WIDTH (8),
        .DEPTH      (16),
        .ADDR_WIDTH (4),
        .NUM_EXPORT (4),
        .RESET_VALS (DEF_RESET_VALS),
        .RO_MASK    (16'h0002),
        .BYPASS     (1'b1)
    ) u0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    reg_file_mp #(
        .DATA_WIDTH (8),
        .DEPTH      (12),
        .ADDR_WIDTH (4),
        .NUM_EXPORT (4),
        .RESET_VALS (DEF_RESET_VALS[95:0]),
        .RO_MASK    (12'h000),
        .BYPASS     (1'b0)
    ) u1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        b0.WrEn = 1'b0; b0.WrAddr = '0; b0.WrData = '0;
        b0.RdEnA = 1'b0; b0.RdAddrA = '0; b0.RdEnB = 1'b0; b0.RdAddrB = '0;
        b1.WrEn = 1'b0; b1.WrAddr = '0; b1.WrData = '0;
        b1.RdEnA = 1'b0; b1.RdAddrA = '0; b1.RdEnB = 1'b0; b1.RdAddrB = '0;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_regout_u0", b0.REG_OUT, 32'h2081_0000);
        check("rst_regout_u1", b1.REG_OUT, 32'h2081_0000);
        check("rst_rddata_a",  {24'h0, b0.RdDataA}, 32'h0);
        check("rst_vld_a",     {31'h0, b0.RdDataA_VLD}, 32'h0);
        check("rst_vld_b",     {31'h0, b0.RdDataB_VLD}, 32'h0);
        check("rst_wrerr",     {31'h0, b0.WrErr}, 32'h0);
        check("rst_rderr",     {31'h0, b0.RdErr}, 32'h0);
        rst = 1'b0;
        tick();

        // Read of reset value, latency 1, then hold
        b0.RdEnA = 1'b1; b0.RdAddrA = 4'd2;
        check("lat_vld_before", {31'h0, b0.RdDataA_VLD}, 32'h0);
        tick();
        check("rd2_data", {24'h0, b0.RdDataA}, 32'h81);
        check("rd2_vld",  {31'h0, b0.RdDataA_VLD}, 32'h1);
        check("rd2_rderr", {31'h0, b0.RdErr}, 32'h0);
        idle();
        tick();
        check("rd2_vld_drop", {31'h0, b0.RdDataA_VLD}, 32'h0);
        check("rd2_hold",     {24'h0, b0.RdDataA}, 32'h81);

        // Write then dual read of the same address
        b0.WrEn = 1'b1; b0.WrAddr = 4'd7; b0.WrData = 8'h5A;
        tick();
        check("wr7_wrerr", {31'h0, b0.WrErr}, 32'h0);
        idle();
        b0.RdEnA = 1'b1; b0.RdAddrA = 4'd7;
        b0.RdEnB = 1'b1; b0.RdAddrB = 4'd7;
        tick();
        check("rd7_a",     {24'h0, b0.RdDataA}, 32'h5A);
        check("rd7_b",     {24'h0, b0.RdDataB}, 32'h5A);
        check("rd7_vld_a", {31'h0, b0.RdDataA_VLD}, 32'h1);
        check("rd7_vld_b", {31'h0, b0.RdDataB_VLD}, 32'h1);
        idle();
        tick();
        check("rd7_vld_a_pulse", {31'h0, b0.RdDataA_VLD}, 32'h0);
        check("rd7_vld_b_pulse", {31'h0, b0.RdDataB_VLD}, 32'h0);

        // Collision: preload 8'h11 at addr 5 on both instances
        b0.WrEn = 1'b1; b0.WrAddr = 4'd5; b0.WrData = 8'h11;
        b1.WrEn = 1'b1; b1.WrAddr = 4'd5; b1.WrData = 8'h11;
        tick();
        b0.WrData = 8'h3C; b0.RdEnA = 1'b1; b0.RdAddrA = 4'd5;
        b0.RdEnB = 1'b1; b0.RdAddrB = 4'd3;
        b1.WrData = 8'h3C; b1.RdEnA = 1'b1; b1.RdAddrA = 4'd5;
        tick();
        check("coll_bypass1",  {24'h0, b0.RdDataA}, 32'h3C);
        check("coll_other_b",  {24'h0, b0.RdDataB}, 32'h20);
        check("coll_bypass0",  {24'h0, b1.RdDataA}, 32'h11);
        idle();
        b1.RdEnA = 1'b1; b1.RdAddrA = 4'd5;
        tick();
        check("coll_after_b0", {24'h0, b1.RdDataA}, 32'h3C);
        idle();

        // Read-only register: write dropped, no bypass
        b0.WrEn = 1'b1; b0.WrAddr = 4'd1; b0.WrData = 8'hFF;
        b0.RdEnA = 1'b1; b0.RdAddrA = 4'd1;
        tick();
        check("ro_wrerr",  {31'h0, b0.WrErr}, 32'h1);
        check("ro_rd_old", {24'h0, b0.RdDataA}, 32'h00);
        check("ro_regout", {24'h0, b0.REG_OUT[15:8]}, 32'h00);
        idle();
        tick();
        check("ro_wrerr_pulse", {31'h0, b0.WrErr}, 32'h0);

        // Out-of-range read and write on the DEPTH=12 instance
        b1.RdEnA = 1'b1; b1.RdAddrA = 4'd13;
        tick();
        check("oor_rd_data",  {24'h0, b1.RdDataA}, 32'h0);
        check("oor_rd_vld",   {31'h0, b1.RdDataA_VLD}, 32'h1);
        check("oor_rd_err",   {31'h0, b1.RdErr}, 32'h1);
        idle();
        b1.RdEnB = 1'b1; b1.RdAddrB = 4'd12;
        tick();
        check("oor_rd_err_b", {31'h0, b1.RdErr}, 32'h1);
        idle();
        tick();
        check("oor_rd_err_pulse", {31'h0, b1.RdErr}, 32'h0);
        b1.WrEn = 1'b1; b1.WrAddr = 4'd12; b1.WrData = 8'h99;
        tick();
        check("oor_wrerr",  {31'h0, b1.WrErr}, 32'h1);
        check("oor_regout", b1.REG_OUT, 32'h2081_0000);
        b1.WrAddr = 4'd11; b1.WrData = 8'hAB;
        tick();
        check("top_wrerr", {31'h0, b1.WrErr}, 32'h0);
        idle();
        b1.RdEnA = 1'b1; b1.RdAddrA = 4'd11;
        tick();
        check("top_rd",     {24'h0, b1.RdDataA}, 32'hAB);
        check("top_rd_err", {31'h0, b1.RdErr}, 32'h0);
        idle();

        // REG_OUT update, then reset while VLD is high
        b0.WrEn = 1'b1; b0.WrAddr = 4'd0; b0.WrData = 8'h77;
        tick();
        check("regout_wr0", b0.REG_OUT, 32'h2081_0077);
        idle();
        b0.RdEnA = 1'b1; b0.RdAddrA = 4'd0;
        tick();
        check("pre_rst_vld",  {31'h0, b0.RdDataA_VLD}, 32'h1);
        check("pre_rst_data", {24'h0, b0.RdDataA}, 32'h77);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_vld",    {31'h0, b0.RdDataA_VLD}, 32'h0);
        check("mid_rst_data",   {24'h0, b0.RdDataA}, 32'h0);
        check("mid_rst_regout", b0.REG_OUT, 32'h2081_0000);
        idle();
        #1;
        rst = 1'b0;
        tick();
        check("post_rst_vld", {31'h0, b0.RdDataA_VLD}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised successor of the system register file. Provides one write port and two independent read ports (A and B), each with its own enable and valid flag. Adds per-register reset values, a read-only protection mask, out-of-range address detection, and an optional write-to-read bypass. Sits between the system controller (write and port A reads) and the datapath/config consumers (port B reads and the exported registers).

Parameters:
DATA_WIDTH, 8, register width in bits
DEPTH, 16, number of registers; need not be a power of two (DEPTH <= 2**ADDR_WIDTH)
ADDR_WIDTH, 4, address width
NUM_EXPORT, 4, number of low registers driven continuously on REG_OUT (1..DEPTH)
RESET_VALS, {DEPTH*DATA_WIDTH{1'b0}}, flattened reset image; register i = bits [i*DATA_WIDTH +: DATA_WIDTH]
RO_MASK, {DEPTH{1'b0}}, bit i = 1 makes register i read-only (writes are dropped)
BYPASS, 1, 1 = a read of the address being written in the same cycle returns WrData; 0 = returns the old contents

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
WrEn  in  1  write request
WrAddr  in  ADDR_WIDTH  write address
WrData  in  DATA_WIDTH  write data
RdEnA  in  1  port A read request
RdAddrA  in  ADDR_WIDTH  port A address
RdDataA  out  DATA_WIDTH  port A read data, registered
RdDataA_VLD  out  1  port A valid, one-cycle pulse
RdEnB / RdAddrB / RdDataB / RdDataB_VLD  as port A, for port B
WrErr  out  1  one-cycle pulse: write was dropped
RdErr  out  1  one-cycle pulse: a read address was out of range
REG_OUT  out  NUM_EXPORT*DATA_WIDTH  live contents of registers 0..NUM_EXPORT-1, register 0 in the LSBs

Behaviour:
- Reset (rst=1, asynchronous):
  - register i loads RESET_VALS slice i;
  - RdDataA, RdDataB = 0;
  - all VLD and Err outputs = 0.
- Release: on deassertion, normal operation starts at the first rising edge with rst=0.
- Write: on an edge with WrEn=1:
  - if WrAddr < DEPTH and RO_MASK[WrAddr]=0, the register updates;
  - otherwise nothing changes and WrErr=1 for one cycle.
- Read: on an edge with RdEnX=1, RdDataX and RdDataX_VLD=1 appear the following cycle (latency 1).
  - If RdEnX=0, VLD returns to 0 and RdDataX holds its last value.
- Ports A and B are fully independent:
  - both may read the same or different addresses in the same cycle;
  - a write and reads may occur in the same cycle (no priority blocking, unlike the previous block).
- Collision when WrEn=1, write accepted, and RdAddrX==WrAddr:
  - BYPASS=1: RdDataX = WrData;
  - BYPASS=0: RdDataX = pre-write contents.
  - A dropped write never bypasses; the read returns the stored value.
- Out-of-range read (RdAddrX >= DEPTH): RdDataX = 0, RdDataX_VLD=1, RdErr=1. RdErr is the OR of both ports.
- REG_OUT is combinational from storage and reflects a write in the cycle after the accepting edge.
- Read-only registers still read normally and keep their RESET_VALS until the next reset.
- Reset mid-operation: any pending VLD or Err is cleared immediately; in-flight reads are discarded.
- No state machine beyond the storage plus per-port output registers. Address compares are unsigned at ADDR_WIDTH.

Decomposition:
- Shared package reg_file_pkg holds:
  - function that extracts reset slice i from RESET_VALS;
  - default localparams (DATA_WIDTH=8, DEPTH=16);
  - system register index constants (e.g. REG_UART_CFG=2, REG_DIV=3) with their reset values 8'h81 and 8'h20 for the default image.
- One sub-module: reg_file_rd_port, instantiated twice. It contains address range check, bypass mux, registered data and valid. Storage, write logic and WrErr stay in the top level.

Test Plan:
- Reset with RESET_VALS reg2=8'h81, reg3=8'h20 -> REG_OUT=32'h2081_0000; port A read of addr 2 gives 8'h81 with VLD one cycle later.
- Write 8'h5A to addr 7, then next cycle RdEnA addr 7 and RdEnB addr 7 -> both RdData=8'h5A, both VLD=1 for exactly one cycle.
- Same-cycle WrEn addr 5 data 8'h3C with RdEnA addr 5 (old contents 8'h11):
  - BYPASS=1 -> 8'h3C;
  - BYPASS=0 -> 8'h11; a following read -> 8'h3C.
- RO_MASK bit 1 set, write 8'hFF to addr 1 -> WrErr pulse, REG_OUT[15:8] unchanged; same-cycle read of addr 1 returns the old value even with BYPASS=1.
- DEPTH=12: read addr 13 -> RdData=0, VLD=1, RdErr=1; write addr 12 -> WrErr=1 and storage unchanged.
- Assert rst while RdDataA_VLD=1 after writing 8'h77 to addr 0 -> VLD drops immediately and REG_OUT returns to the reset image.
